// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop synchronizer, stable-count debouncer and a
// press/auto-repeat/release event FSM for each button, all channels identical.
module button_conditioner #(
  parameter int                 N_BTN               = 4,
  parameter int                 DEBOUNCE_CYCLES     = 1_000_000,
  parameter int                 REPEAT_DELAY_CYCLES = 25_000_000,
  parameter int                 REPEAT_RATE_CYCLES  = 5_000_000,
  parameter logic [N_BTN-1:0]   REPEAT_MASK         = '1
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [N_BTN-1:0] btn_raw_n,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeating
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int RP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                          REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RP_W-1:0] RR_LAST = RP_W'(REPEAT_RATE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } state_t;

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [N_BTN-1:0] w_sync;
  logic [N_BTN-1:0] r_stable;
  logic [DB_W-1:0]  r_db_cnt [N_BTN];
  logic [N_BTN-1:0] w_accept;
  logic [N_BTN-1:0] w_rise;
  logic [N_BTN-1:0] w_fall;

  state_t           r_state     [N_BTN];
  state_t           w_state_nxt [N_BTN];
  logic [RP_W-1:0]  r_rp_cnt    [N_BTN];
  logic [RP_W-1:0]  w_rp_nxt    [N_BTN];
  logic [N_BTN-1:0] w_press_nxt;
  logic [N_BTN-1:0] w_release_nxt;
  logic [N_BTN-1:0] r_press;
  logic [N_BTN-1:0] r_release;
  logic [N_BTN-1:0] r_repeating;

  // Synchronizer resets to "released" so a held button is a fresh press.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= btn_raw_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sync = ~r_sync2;

  // Edge events are decoded from the debouncer's acceptance condition so the
  // FSM reacts on the same edge that updates the stable level.
  always_comb begin
    w_accept = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      w_accept[i] = (w_sync[i] != r_stable[i]) && (r_db_cnt[i] == DB_LAST);
    end
    w_rise = w_accept & w_sync;
    w_fall = w_accept & ~w_sync;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_stable <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (w_sync[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_stable[i] <= w_sync[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_press_nxt   = '0;
    w_release_nxt = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      w_state_nxt[i] = r_state[i];
      w_rp_nxt[i]    = r_rp_cnt[i];
      // A release always wins over a repeat due on the same cycle.
      if (w_fall[i]) begin
        w_release_nxt[i] = 1'b1;
        w_state_nxt[i]   = ST_IDLE;
        w_rp_nxt[i]      = '0;
      end else begin
        case (r_state[i])
          ST_IDLE: begin
            if (w_rise[i]) begin
              w_press_nxt[i] = 1'b1;
              w_rp_nxt[i]    = '0;
              w_state_nxt[i] = ST_DELAY;
            end
          end
          ST_DELAY: begin
            if (r_rp_cnt[i] == RD_LAST) begin
              if (REPEAT_MASK[i]) begin
                w_press_nxt[i] = 1'b1;
                w_rp_nxt[i]    = '0;
                w_state_nxt[i] = ST_REPEAT;
              end
            end else begin
              w_rp_nxt[i] = r_rp_cnt[i] + RP_W'(1);
            end
          end
          ST_REPEAT: begin
            if (r_rp_cnt[i] == RR_LAST) begin
              w_press_nxt[i] = 1'b1;
              w_rp_nxt[i]    = '0;
            end else begin
              w_rp_nxt[i] = r_rp_cnt[i] + RP_W'(1);
            end
          end
          default: begin
            w_state_nxt[i] = ST_IDLE;
            w_rp_nxt[i]    = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_press     <= '0;
      r_release   <= '0;
      r_repeating <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        r_state[i]  <= ST_IDLE;
        r_rp_cnt[i] <= '0;
      end
    end else begin
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        r_state[i]     <= w_state_nxt[i];
        r_rp_cnt[i]    <= w_rp_nxt[i];
        r_repeating[i] <= (w_state_nxt[i] == ST_REPEAT);
      end
    end
  end

  assign btn_level     = r_stable;
  assign btn_press     = r_press;
  assign btn_release   = r_release;
  assign btn_repeating = r_repeating;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: reset, debounce latency, bounce
// rejection, auto-repeat cadence, masked repeat and release/repeat collision.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] raw;
  logic [3:0] level;
  logic [3:0] press;
  logic [3:0] rel;
  logic [3:0] rpt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN              (4),
    .DEBOUNCE_CYCLES    (4),
    .REPEAT_DELAY_CYCLES(10),
    .REPEAT_RATE_CYCLES (3),
    .REPEAT_MASK        (4'b1101)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .btn_raw_n    (raw),
    .btn_level    (level),
    .btn_press    (press),
    .btn_release  (rel),
    .btn_repeating(rpt)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    raw   = 4'b1111;
    tick(2);
    total++;
    if ({level, press, rel, rpt} !== 16'h0000) begin
      bad++;
      $display("FAIL reset_init got=%h exp=0000", {level, press, rel, rpt});
    end
    rst_n = 1'b1;
    tick(3);
    raw[0] = 1'b0;
    tick(8);
    total++;
    if (level !== 4'b0001) begin
      bad++;
      $display("FAIL pre_reset_level got=%b exp=0001", level);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({level, press, rel, rpt} !== 16'h0000) begin
      bad++;
      $display("FAIL reset_mid got=%h exp=0000", {level, press, rel, rpt});
    end
    tick(2);
    rst_n = 1'b1;
    tick(5);
    total++;
    if (level !== 4'b0000 || press !== 4'b0000) begin
      bad++;
      $display("FAIL held_e5 got=%b/%b exp=0000/0000", level, press);
    end
    tick(1);
    total++;
    if (level !== 4'b0001 || press !== 4'b0001) begin
      bad++;
      $display("FAIL held_e6 got=%b/%b exp=0001/0001", level, press);
    end
    tick(1);
    total++;
    if (press !== 4'b0000) begin
      bad++;
      $display("FAIL held_width got=%b exp=0000", press);
    end
    raw[0] = 1'b1;
    tick(6);
    total++;
    if (rel !== 4'b0001 || level !== 4'b0000) begin
      bad++;
      $display("FAIL held_release got=%b/%b exp=0001/0000", rel, level);
    end
    tick(4);
  endtask

  task automatic test_clean();
    raw[0] = 1'b0;
    tick(5);
    total++;
    if (press !== 4'b0000 || level !== 4'b0000) begin
      bad++;
      $display("FAIL clean_e5 got=%b/%b exp=0000/0000", press, level);
    end
    tick(1);
    total++;
    if (press !== 4'b0001 || level !== 4'b0001 || rel !== 4'b0000) begin
      bad++;
      $display("FAIL clean_press got=%b/%b/%b exp=0001/0001/0000", press, level, rel);
    end
    tick(1);
    total++;
    if (press !== 4'b0000 || level !== 4'b0001) begin
      bad++;
      $display("FAIL clean_width got=%b/%b exp=0000/0001", press, level);
    end
    raw[0] = 1'b1;
    tick(5);
    total++;
    if (rel !== 4'b0000 || level !== 4'b0001) begin
      bad++;
      $display("FAIL clean_rel_e5 got=%b/%b exp=0000/0001", rel, level);
    end
    tick(1);
    total++;
    if (rel !== 4'b0001 || level !== 4'b0000 || press !== 4'b0000) begin
      bad++;
      $display("FAIL clean_release got=%b/%b/%b exp=0001/0000/0000", rel, level, press);
    end
    tick(1);
    total++;
    if (rel !== 4'b0000) begin
      bad++;
      $display("FAIL clean_rel_width got=%b exp=0000", rel);
    end
    tick(4);
  endtask

  task automatic test_bounce();
    int widths[10] = '{2, 1, 3, 1, 2, 3, 1, 2, 3, 2};
    int pulses = 0;
    for (int i = 0; i < 10; i++) begin
      raw[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      for (int j = 0; j < widths[i]; j++) begin
        tick(1);
        if ((press | rel) !== 4'b0000) pulses++;
      end
    end
    total++;
    if (pulses !== 0 || level !== 4'b0000) begin
      bad++;
      $display("FAIL bounce_quiet got=%0d/%b exp=0/0000", pulses, level);
    end
    raw[0] = 1'b0;
    tick(5);
    total++;
    if (press !== 4'b0000) begin
      bad++;
      $display("FAIL bounce_e5 got=%b exp=0000", press);
    end
    tick(1);
    total++;
    if (press !== 4'b0001) begin
      bad++;
      $display("FAIL bounce_press got=%b exp=0001", press);
    end
    tick(1);
    total++;
    if (press !== 4'b0000) begin
      bad++;
      $display("FAIL bounce_width got=%b exp=0000", press);
    end
    raw[0] = 1'b1;
    tick(10);
  endtask

  task automatic test_auto_repeat();
    logic ep, er, erp;
    raw[0] = 1'b0;
    tick(6);
    total++;
    if (press !== 4'b0001) begin
      bad++;
      $display("FAIL rpt_press0 got=%b exp=0001", press);
    end
    for (int k = 1; k <= 37; k++) begin
      tick(1);
      ep  = (k >= 10 && k < 36 && (k - 10) % 3 == 0);
      er  = (k == 36);
      erp = (k >= 10 && k < 36);
      total++;
      if (press[0] !== ep || rel[0] !== er || rpt[0] !== erp) begin
        bad++;
        $display("FAIL rpt_k%0d got=%b%b%b exp=%b%b%b", k, press[0], rel[0], rpt[0], ep, er, erp);
      end
      if (k == 30) raw[0] = 1'b1;
    end
    tick(4);
  endtask

  task automatic test_masked();
    int np = 0;
    int nr = 0;
    raw[1] = 1'b0;
    tick(6);
    total++;
    if (press !== 4'b0010) begin
      bad++;
      $display("FAIL mask_press got=%b exp=0010", press);
    end
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (press[1] !== 1'b0) np++;
      if (rpt[1] !== 1'b0) nr++;
    end
    total++;
    if (np !== 0 || nr !== 0 || level !== 4'b0010) begin
      bad++;
      $display("FAIL mask_hold got=%0d/%0d/%b exp=0/0/0010", np, nr, level);
    end
    raw[1] = 1'b1;
    tick(6);
    total++;
    if (rel !== 4'b0010 || level !== 4'b0000) begin
      bad++;
      $display("FAIL mask_release got=%b/%b exp=0010/0000", rel, level);
    end
    tick(4);
  endtask

  task automatic test_collision();
    logic [3:0] ep, er, erp;
    raw = 4'b1010;
    tick(6);
    total++;
    if (press !== 4'b0101 || level !== 4'b0101) begin
      bad++;
      $display("FAIL coll_press got=%b/%b exp=0101/0101", press, level);
    end
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      ep     = '0;
      er     = '0;
      erp    = '0;
      ep[0]  = (k == 10 || k == 13);
      er[0]  = (k == 16);
      erp[0] = (k >= 10 && k < 16);
      ep[2]  = (k >= 10 && (k - 10) % 3 == 0);
      erp[2] = (k >= 10);
      total++;
      if (press !== ep || rel !== er || rpt !== erp) begin
        bad++;
        $display("FAIL coll_k%0d got=%b/%b/%b exp=%b/%b/%b", k, press, rel, rpt, ep, er, erp);
      end
      if (k == 10) raw[0] = 1'b1;
    end
    raw[2] = 1'b1;
    tick(6);
    total++;
    if (rel !== 4'b0100 || press !== 4'b0000 || rpt !== 4'b0000) begin
      bad++;
      $display("FAIL coll_rel2 got=%b/%b/%b exp=0100/0000/0000", rel, press, rpt);
    end
    tick(4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clean();
    test_bounce();
    test_auto_repeat();
    test_masked();
    test_collision();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
